// File: rtl/gearbox_1_to_n.sv
// gearbox_1_to_n: width-up gearbox packing n upstream words of `width` bits into one
// downstream word of n*width bits, with valid/ready handshakes on both sides, a registered
// output stage and an up_last flush that emits a partially filled word plus a keep mask.
//
// Slot ordering: the first word of a group lands in the most significant slot (n-1);
// the k-th word lands in slot n-1-k. Unfilled lower slots of a flushed word are zero.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   up_vld     upstream word valid
//   up_rdy     block accepts a word this cycle (combinational on state, down_rdy, up_last)
//   up_data    upstream word
//   up_last    marks up_data as last of a burst; forces emission of the group
//   down_vld   downstream word valid (registered)
//   down_rdy   downstream consumer accepts this cycle
//   down_data  packed word, slot i at down_data[i*width +: width]
//   down_keep  per-slot valid mask, bit i qualifies slot i
module gearbox_1_to_n #(
  parameter int unsigned width = 8,
  parameter int unsigned n     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_vld,
  output logic                 up_rdy,
  input  logic [width-1:0]     up_data,
  input  logic                 up_last,
  output logic                 down_vld,
  input  logic                 down_rdy,
  output logic [n*width-1:0]   down_data,
  output logic [n-1:0]         down_keep
);

  localparam int unsigned CntW = $clog2(n);
  localparam logic [CntW-1:0] CntLast = CntW'(n - 1);

  // Accumulator holds slots n-1..1; slot s lives at acc[(s-1)*width +: width].
  // Slot 0 is only ever filled by the completing word, so it needs no storage.
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [(n-1)*width-1:0]   acc_q, acc_d;
  logic                     down_vld_q, down_vld_d;
  logic [n*width-1:0]       down_data_q, down_data_d;
  logic [n-1:0]             down_keep_q, down_keep_d;

  logic out_stall;
  logic up_beat;
  logic down_beat;
  logic group_done;
  int   ins_slot;

  // Handshake decode. Only a completing beat needs the output register, so a
  // stalled output blocks just that beat.
  always_comb begin
    out_stall  = down_vld_q && !down_rdy;
    up_rdy     = !out_stall || ((cnt_q != CntLast) && !up_last);
    up_beat    = up_vld && up_rdy;
    down_beat  = down_vld_q && down_rdy;
    group_done = up_beat && ((cnt_q == CntLast) || up_last);
    ins_slot   = int'(n) - 1 - int'(cnt_q);
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    down_vld_d  = down_vld_q;
    down_data_d = down_data_q;
    down_keep_d = down_keep_q;

    if (group_done) begin
      // Accumulated slots below ins_slot are zero (acc is cleared per group).
      down_data_d = '0;
      down_keep_d = '0;
      for (int s = 1; s < int'(n); s++) begin
        down_data_d[s*width +: width] = acc_q[(s-1)*width +: width];
      end
      for (int s = 0; s < int'(n); s++) begin
        if (s == ins_slot) begin
          down_data_d[s*width +: width] = up_data;
        end
        down_keep_d[s] = (s >= ins_slot);
      end
      down_vld_d = 1'b1;
      cnt_d      = '0;
      acc_d      = '0;
    end else begin
      if (down_beat) begin
        down_vld_d = 1'b0;
      end
      if (up_beat) begin
        for (int s = 1; s < int'(n); s++) begin
          if (s == ins_slot) begin
            acc_d[(s-1)*width +: width] = up_data;
          end
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      down_vld_q  <= 1'b0;
      down_data_q <= '0;
      down_keep_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      down_vld_q  <= down_vld_d;
      down_data_q <= down_data_d;
      down_keep_q <= down_keep_d;
    end
  end

  assign down_vld  = down_vld_q;
  assign down_data = down_data_q;
  assign down_keep = down_keep_q;

endmodule

// File: tb/tb_gearbox_1_to_n.sv
// Testbench for gearbox_1_to_n. A queue-based reference model of the packing rules is
// compared against the main instance (width=8, n=4) on every negedge; directed scenarios
// pin the emitted words to literal values; two extra instances cover n=2 and n=3.
module tb_gearbox_1_to_n;

  localparam int W = 8;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              up_vld, up_rdy, up_last, down_vld, down_rdy;
  logic [W-1:0]      up_data;
  logic [N*W-1:0]    down_data;
  logic [N-1:0]      down_keep;

  // n=2, width=16 instance
  logic        b_vld, b_rdy, b_last, b_down_vld;
  logic [15:0] b_data;
  logic [31:0] b_down_data;
  logic [1:0]  b_down_keep;
  // n=3, width=8 instance
  logic        c_vld, c_rdy, c_last, c_down_vld;
  logic [7:0]  c_data;
  logic [23:0] c_down_data;
  logic [2:0]  c_down_keep;

  gearbox_1_to_n #(.width(W), .n(N)) dut (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy), .up_data(up_data),
    .up_last(up_last), .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data),
    .down_keep(down_keep)
  );

  gearbox_1_to_n #(.width(16), .n(2)) dut_b (
    .clk(clk), .rst(rst), .up_vld(b_vld), .up_rdy(b_rdy), .up_data(b_data),
    .up_last(b_last), .down_vld(b_down_vld), .down_rdy(1'b1), .down_data(b_down_data),
    .down_keep(b_down_keep)
  );

  gearbox_1_to_n #(.width(8), .n(3)) dut_c (
    .clk(clk), .rst(rst), .up_vld(c_vld), .up_rdy(c_rdy), .up_data(c_data),
    .up_last(c_last), .down_vld(c_down_vld), .down_rdy(1'b1), .down_data(c_down_data),
    .down_keep(c_down_keep)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit           chk_en = 0;
  bit           m_vld = 0;
  logic [31:0]  m_data = '0;
  logic [3:0]   m_keep = '0;
  logic [7:0]   m_grp[$];
  logic [35:0]  got[$];   // {keep, data} of every downstream beat seen

  // Compare DUT against model, then advance the model with the inputs held until the
  // next posedge.
  initial begin
    bit exp_rdy, ub, db;
    forever begin
      @(negedge clk);
      exp_rdy = !(m_vld && !down_rdy) || ((m_grp.size() != N - 1) && !up_last);
      if (chk_en) begin
        check("down_vld", down_vld, m_vld);
        check("down_data", down_data, m_data);
        check("down_keep", down_keep, m_keep);
        check("up_rdy", up_rdy, exp_rdy);
        if (down_vld === 1'b1 && down_rdy) got.push_back({down_keep, down_data});
      end
      if (rst) begin
        m_vld = 0; m_data = '0; m_keep = '0; m_grp.delete();
      end else begin
        ub = up_vld && exp_rdy;
        db = m_vld && down_rdy;
        if (ub) m_grp.push_back(up_data);
        if (ub && (m_grp.size() == N || up_last)) begin
          m_data = '0;
          m_keep = '0;
          foreach (m_grp[k]) begin
            m_data[(N-1-k)*W +: W] = m_grp[k];
            m_keep[N-1-k] = 1'b1;
          end
          m_vld = 1;
          m_grp.delete();
        end else if (db) begin
          m_vld = 0;
        end
      end
    end
  end

  task automatic idle(input int k);
    up_vld = 0; up_last = 0; up_data = 8'hFF;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    up_vld = 1; up_data = d; up_last = last;
    forever begin
      @(negedge clk);
      if (up_rdy === 1'b1) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        check("send_timeout", t, 0);
        break;
      end
    end
    up_vld = 0; up_last = 0; up_data = 8'hFF;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [35:0] exp);
    if (idx < got.size()) check(name, got[idx], exp);
    else check({name, "_missing"}, got.size(), idx + 1);
  endtask

  initial begin
    up_vld = 0; up_data = '0; up_last = 0; down_rdy = 1;
    b_vld = 0; b_data = '0; b_last = 0;
    c_vld = 0; c_data = '0; c_last = 0;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 rst = 0;
    check("reset_vld", down_vld, 0);
    check("reset_data", down_data, 0);
    check("reset_keep", down_keep, 0);
    check("reset_rdy", up_rdy, 1);

    // Full-rate packing
    got.delete();
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    idle(3);
    check("fullrate_count", got.size(), 2);
    chk_got("fullrate_w0", 0, {4'hF, 32'h01020304});
    chk_got("fullrate_w1", 1, {4'hF, 32'h05060708});

    // Gapped input; 0xFF presented while up_vld=0
    got.delete();
    for (int i = 1; i <= 8; i++) begin send(8'(i), 1'b0); idle(1); end
    idle(3);
    check("gapped_count", got.size(), 2);
    chk_got("gapped_w0", 0, {4'hF, 32'h01020304});
    chk_got("gapped_w1", 1, {4'hF, 32'h05060708});

    // Backpressure
    got.delete();
    down_rdy = 0;
    fork
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      begin repeat (12) @(posedge clk); #1 down_rdy = 1; end
    join
    idle(3);
    check("bp_count", got.size(), 2);
    chk_got("bp_w0", 0, {4'hF, 32'h01020304});
    chk_got("bp_w1", 1, {4'hF, 32'h05060708});

    // Partial flush
    got.delete();
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    send(8'hCC, 1'b0); send(8'hDD, 1'b0); send(8'hEE, 1'b0); send(8'hFF, 1'b0);
    idle(3);
    check("flush_count", got.size(), 2);
    chk_got("flush_w0", 0, {4'b1100, 32'hAABB0000});
    chk_got("flush_w1", 1, {4'hF, 32'hCCDDEEFF});

    // Reset mid-word
    got.delete();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    rst = 1;
    @(posedge clk); #1;
    check("midrst_vld", down_vld, 0);
    check("midrst_data", down_data, 0);
    rst = 0;
    send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    idle(3);
    check("midrst_count", got.size(), 1);
    chk_got("midrst_w0", 0, {4'hF, 32'h44556677});

    // Reset with a stalled output word
    down_rdy = 0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    idle(2);
    check("stall_vld_before", down_vld, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    check("stall_vld_after", down_vld, 0);
    down_rdy = 1;
    idle(2);

    // Ratio sweep: n=2/width=16 and n=3 single-word flush
    check("b_rdy", b_rdy, 1);
    b_vld = 1; b_data = 16'hA1A1;
    c_vld = 1; c_data = 8'h5A; c_last = 1;
    @(posedge clk); #1;
    b_data = 16'hB2B2; c_vld = 0; c_last = 0;
    @(negedge clk);
    check("c_vld", c_down_vld, 1);
    check("c_keep", c_down_keep, 3'b100);
    check("c_data", c_down_data, 24'h5A0000);
    @(posedge clk); #1 b_vld = 0;
    @(negedge clk);
    check("b_vld", b_down_vld, 1);
    check("b_data", b_down_data, 32'hA1A1B2B2);
    check("b_keep", b_down_keep, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_vld_clear", b_down_vld, 0);
    @(posedge clk); #1;

    // Randomised traffic against the model
    repeat (3000) begin
      up_vld   = ($urandom_range(0, 3) != 0);
      up_data  = 8'($urandom);
      up_last  = ($urandom_range(0, 7) == 0);
      down_rdy = ($urandom_range(0, 9) < 7);
      rst      = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 0; down_rdy = 1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gearbox_1_to_n.md
Name: gearbox_1_to_n

Overview:
Parametrised width-up gearbox that packs n consecutive upstream words of `width` bits into one downstream word of n*width bits. It carries the 1-to-2 packing scheme forward with these additions:
- a generic ratio,
- valid/ready backpressure on both sides,
- a registered output stage,
- an `up_last` flush that emits a partially filled word with a per-slot keep mask.

It sits between narrow producers and wide consumers in the streaming datapath.

Parameters:
width  8  bits per upstream word; must be >= 1
n      4  packing ratio (upstream words per downstream word); must be >= 2

Ports:
clk        input   1          clock, all state updates on posedge
rst        input   1          synchronous reset, active-high
up_vld     input   1          upstream word valid
up_rdy     output  1          block can accept a word this cycle
up_data    input   width      upstream word
up_last    input   1          qualifies up_data as last of burst; forces emission
down_vld   output  1          downstream word valid (registered)
down_rdy   input   1          downstream consumer accepts this cycle
down_data  output  n*width    packed word
down_keep  output  n          per-slot valid mask; bit i qualifies down_data[i*width +: width]

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - rst high at a posedge: down_vld=0, down_data=0, down_keep=0, fill count=0, accumulator cleared.
  - Reset mid-word discards the partial accumulation. Reset while down_vld=1 drops the pending word.
  - up_rdy is 1 in the first cycle after reset.
- Transfers:
  - Upstream beat = up_vld && up_rdy.
  - Downstream beat = down_vld && down_rdy.
  - No other condition changes state.
- Slot ordering:
  - The first word of a group lands in the most significant slot, slot n-1; the k-th word (k from 0) lands in slot n-1-k.
  - For n=2 this gives {first, second}.
- Accumulator:
  - Holds n-1 slots plus fill count cnt, range 0..n-1.
  - An upstream beat with cnt<n-1 and up_last=0 stores the word at slot n-1-cnt and increments cnt.
- Completion: an upstream beat with cnt==n-1, or with up_last=1 at any cnt, completes the group. At the next posedge:
  - down_data = accumulated slots plus the current word in slot n-1-cnt; unfilled lower slots are zero.
  - down_keep has ones in slots n-1 down to n-1-cnt and zeros below, e.g. n=4, cnt=1 gives 4'b1100.
  - down_vld is set to 1 and cnt is reset to 0.
- Latency: one cycle from the completing upstream beat to down_vld.
- Output register:
  - down_vld, down_data and down_keep hold stable while down_vld=1 and down_rdy=0.
  - A downstream beat with no completion in the same cycle clears down_vld. down_data and down_keep keep their old values.
- up_rdy:
  - up_rdy = !(down_vld && !down_rdy) || (cnt != n-1 && !up_last).
  - Only a completing beat is stalled by a full output register.
  - up_rdy depends combinationally on down_rdy, up_last and state. No combinational path from up_data.
- Simultaneous events: a downstream beat and a completing upstream beat in the same cycle load the new word and leave down_vld=1. Full throughput is one downstream word every n cycles with no bubbles.
- Flush edge cases:
  - up_last with cnt==n-1 is a normal full word; keep is all ones.
  - up_last on the first word gives keep = one-hot MSB slot.
- up_vld=0 leaves all state unchanged; data on up_data is ignored.
- No combinational path from up_data to down_data.

Test Plan:
1. Full-rate packing (width=8, n=4, down_rdy=1): stream 01..08 with up_vld=1 every cycle. Expect:
   - down_data=32'h01020304, keep=4'hF, one cycle after word 04.
   - down_data=32'h05060708 four cycles later.
   - down_vld high for exactly one cycle each time; up_rdy stays 1 throughout.
2. Gapped input: same data with up_vld toggling 1,0,1,0. Expect the same two words, each one cycle after its 4th accepted beat; words sent while up_vld=0 (e.g. 0xFF) never appear.
3. Backpressure: hold down_rdy=0 and stream 8 words. Expect:
   - The first packed word (01020304) is held stable.
   - up_rdy drops only when the 8th word (08) is presented with cnt=3.
   - After down_rdy rises, 01020304 completes, 08 is accepted in the same cycle, and 05060708 follows next cycle. No loss, no duplication.
4. Partial flush: send AA, then BB with up_last=1. Expect down_data=32'hAABB0000 and keep=4'b1100. The next group starts at slot 3: CC,DD,EE,FF gives 32'hCCDDEEFF.
5. Reset mid-operation: send 11,22,33, assert rst for one cycle, then send 44,55,66,77. Expect:
   - No output containing 11, 22 or 33.
   - Outputs are 0 during reset.
   - Next output is 32'h44556677.
   Repeat with rst asserted while a word is stalled (down_rdy=0): down_vld=0 after reset.
6. Ratio sweep: n=2, width=16: A1A1,B2B2 gives 32'hA1A1B2B2. n=3: up_last on the first word gives keep=3'b100.
